// File: rtl/pic_bus_sequencer.sv
// Bus master that programs a cascade of 8259-style PICs (ICW1-ICW4 + OCW1 per chip)
// and then issues single runtime OCW writes on host request.
module pic_bus_sequencer #(
    parameter int unsigned NUM_PICS    = 7,
    parameter int unsigned WR_LOW      = 2,
    parameter logic [7:0]  VECTOR_BASE = 8'h08
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [7:0]            icw4_master_i,
    input  logic [7:0]            icw4_slave_i,
    input  logic [8*NUM_PICS-1:0] imr_cfg_i,
    input  logic                  ocw_req_i,
    input  logic [2:0]            ocw_target_i,
    input  logic                  ocw_a0_i,
    input  logic [7:0]            ocw_data_i,
    output logic                  ocw_ack_o,
    output logic                  ocw_err_o,
    output logic [7:0]            data_out_o,
    output logic                  data_oe_o,
    output logic                  a0_o,
    output logic [NUM_PICS-1:0]   chip_select_o,
    output logic                  write_flag_o,
    output logic                  read_flag_o,
    output logic                  busy_o,
    output logic                  init_done_o
);

    localparam int unsigned   CntW       = (WR_LOW > 1) ? $clog2(WR_LOW) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(WR_LOW - 1);
    localparam logic [2:0]    LastChip   = 3'(NUM_PICS - 1);
    // Master ICW3: one bit per cascaded slave input (IR1..IR(NUM_PICS-1)).
    localparam logic [7:0]    MasterIcw3 = 8'(((1 << NUM_PICS) - 1) & 8'hFE);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StGap} state_e;

    state_e                state_q;
    logic [2:0]            chip_q;
    logic [2:0]            step_q;
    logic [CntW-1:0]       cnt_q;
    logic                  rt_q;
    logic                  ack_q;
    logic                  err_q;
    logic [7:0]            data_q;
    logic                  oe_q;
    logic                  a0_q;
    logic [NUM_PICS-1:0]   cs_q;
    logic                  wf_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  last_step;
    logic                  last_chip;
    logic [2:0]            ld_chip;
    logic [2:0]            ld_step;
    logic [7:0]            imr_sel;
    logic                  init_a0;
    logic [7:0]            init_data;
    logic [NUM_PICS-1:0]   init_cs;
    logic [NUM_PICS-1:0]   rt_cs;
    logic                  rt_bad;
    logic                  rt_take;

    always_comb begin
        last_step = (step_q == 3'd4);
        last_chip = (chip_q == LastChip);

        // Indices of the write about to be loaded into SETUP.
        if (state_q == StIdle) begin
            ld_chip = 3'd0;
            ld_step = 3'd0;
        end else if (last_step) begin
            ld_chip = chip_q + 3'd1;
            ld_step = 3'd0;
        end else begin
            ld_chip = chip_q;
            ld_step = step_q + 3'd1;
        end

        imr_sel = 8'h00;
        init_cs = '1;
        rt_cs   = '1;
        for (int unsigned i = 0; i < NUM_PICS; i++) begin
            if (ld_chip == 3'(i)) begin
                imr_sel    = imr_cfg_i[8*i +: 8];
                init_cs[i] = 1'b0;
            end
            if (ocw_target_i == 3'(i)) begin
                rt_cs[i] = 1'b0;
            end
        end

        init_a0   = 1'b1;
        init_data = 8'h00;
        case (ld_step)
            3'd0: begin
                init_a0   = 1'b0;
                init_data = 8'h11;
            end
            3'd1: init_data = VECTOR_BASE + {2'b00, ld_chip, 3'b000};
            3'd2: init_data = (ld_chip == 3'd0) ? MasterIcw3 : {5'b00000, ld_chip - 3'd1};
            3'd3: init_data = (ld_chip == 3'd0) ? icw4_master_i : icw4_slave_i;
            3'd4: init_data = imr_sel;
            default: init_data = 8'h00;
        endcase

        rt_bad  = (32'(ocw_target_i) >= NUM_PICS);
        // The ack/err cycle is skipped so a still-held request is not taken twice.
        rt_take = ocw_req_i && done_q && !ack_q && !err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            chip_q  <= 3'd0;
            step_q  <= 3'd0;
            cnt_q   <= '0;
            rt_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= 8'h00;
            oe_q    <= 1'b0;
            a0_q    <= 1'b1;
            cs_q    <= '1;
            wf_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StSetup;
                        rt_q    <= 1'b0;
                        chip_q  <= 3'd0;
                        step_q  <= 3'd0;
                        cs_q    <= init_cs;
                        a0_q    <= init_a0;
                        data_q  <= init_data;
                        oe_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else if (rt_take) begin
                        if (rt_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= StSetup;
                            rt_q    <= 1'b1;
                            cs_q    <= rt_cs;
                            a0_q    <= ocw_a0_i;
                            data_q  <= ocw_data_i;
                            oe_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StSetup: begin
                    state_q <= StStrobe;
                    wf_q    <= 1'b0;
                    cnt_q   <= '0;
                end
                StStrobe: begin
                    if (cnt_q == CntLast) begin
                        state_q <= StHold;
                        wf_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    state_q <= StGap;
                    cs_q    <= '1;
                    oe_q    <= 1'b0;
                end
                StGap: begin
                    if (rt_q) begin
                        state_q <= StIdle;
                        rt_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                    end else if (last_step && last_chip) begin
                        state_q <= StIdle;
                        chip_q  <= 3'd0;
                        step_q  <= 3'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StSetup;
                        chip_q  <= ld_chip;
                        step_q  <= ld_step;
                        cs_q    <= init_cs;
                        a0_q    <= init_a0;
                        data_q  <= init_data;
                        oe_q    <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ocw_ack_o     = ack_q;
    assign ocw_err_o     = err_q;
    assign data_out_o    = data_q;
    assign data_oe_o     = oe_q;
    assign a0_o          = a0_q;
    assign chip_select_o = cs_q;
    assign write_flag_o  = wf_q;
    assign read_flag_o   = 1'b1;
    assign busy_o        = busy_q;
    assign init_done_o   = done_q;

endmodule

// File: tb/tb_pic_bus_sequencer.sv
// Directed bench for pic_bus_sequencer: default instance plus a WR_LOW=1 instance
// sharing start/config, with a continuous bus-protocol monitor.
module tb_pic_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, req, req1, ra0;
    logic [7:0]  icw4_m, icw4_s, rdata;
    logic [55:0] imr;
    logic [2:0]  tgt;

    logic       ack0, err0, oe0, a00, wf0, rf0, busy0, idone0;
    logic [7:0] dout0;
    logic [6:0] cs0;
    logic       ack1, err1, oe1, a01, wf1, rf1, busy1, idone1;
    logic [7:0] dout1;
    logic [6:0] cs1;

    pic_bus_sequencer #(.NUM_PICS(7), .WR_LOW(2), .VECTOR_BASE(8'h08)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .icw4_master_i(icw4_m),
        .icw4_slave_i(icw4_s), .imr_cfg_i(imr), .ocw_req_i(req), .ocw_target_i(tgt),
        .ocw_a0_i(ra0), .ocw_data_i(rdata), .ocw_ack_o(ack0), .ocw_err_o(err0),
        .data_out_o(dout0), .data_oe_o(oe0), .a0_o(a00), .chip_select_o(cs0),
        .write_flag_o(wf0), .read_flag_o(rf0), .busy_o(busy0), .init_done_o(idone0)
    );

    pic_bus_sequencer #(.NUM_PICS(7), .WR_LOW(1), .VECTOR_BASE(8'h08)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .icw4_master_i(icw4_m),
        .icw4_slave_i(icw4_s), .imr_cfg_i(imr), .ocw_req_i(req1), .ocw_target_i(tgt),
        .ocw_a0_i(ra0), .ocw_data_i(rdata), .ocw_ack_o(ack1), .ocw_err_o(err1),
        .data_out_o(dout1), .data_oe_o(oe1), .a0_o(a01), .chip_select_o(cs1),
        .write_flag_o(wf1), .read_flag_o(rf1), .busy_o(busy1), .init_done_o(idone1)
    );

    typedef struct packed {
        logic [6:0] cs;
        logic       a0;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int         chip;
        int         step;
        logic       a0;
        logic [7:0] data;
    } wr_vec_t;

    wr_t     wq[$];
    wr_vec_t vecs[16];

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int pulses1 = 0, wide1 = 0, run1 = 0;
    logic wf0_prev = 1'b1, wf1_prev = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Write capture on DUT0, pulse-width tracking on DUT1, protocol rules on both.
    always @(negedge clk) begin
        if (wf0_prev && !wf0) wq.push_back('{cs0, a00, dout0});
        wf0_prev = wf0;
        if (!wf1) begin
            run1++;
            if (wf1_prev) pulses1++;
            if (run1 > 1) wide1++;
        end else begin
            run1 = 0;
        end
        wf1_prev = wf1;
        if ($countones(~cs0) > 1 || (!wf0 && &cs0) || (!(&cs0) && !oe0) || !rf0) viol++;
        if ($countones(~cs1) > 1 || (!wf1 && &cs1) || (!(&cs1) && !oe1) || !rf1) viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cycles, acks, c, n, idx;
        logic [6:0] ecs;

        rst_n = 1'b0; start = 1'b0; req = 1'b0; req1 = 1'b0;
        tgt = 3'd0; ra0 = 1'b0; rdata = 8'h00;
        icw4_m = 8'h05; icw4_s = 8'h01;
        imr = {8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};

        vecs[0]  = '{0, 0, 1'b0, 8'h11};
        vecs[1]  = '{0, 1, 1'b1, 8'h08};
        vecs[2]  = '{0, 2, 1'b1, 8'h7E};
        vecs[3]  = '{0, 3, 1'b1, 8'h05};
        vecs[4]  = '{0, 4, 1'b1, 8'hA0};
        vecs[5]  = '{3, 0, 1'b0, 8'h11};
        vecs[6]  = '{3, 1, 1'b1, 8'h20};
        vecs[7]  = '{3, 2, 1'b1, 8'h02};
        vecs[8]  = '{3, 3, 1'b1, 8'h01};
        vecs[9]  = '{3, 4, 1'b1, 8'hA3};
        vecs[10] = '{6, 1, 1'b1, 8'h38};
        vecs[11] = '{6, 2, 1'b1, 8'h05};
        vecs[12] = '{6, 3, 1'b1, 8'h01};
        vecs[13] = '{6, 4, 1'b1, 8'hA6};
        vecs[14] = '{1, 1, 1'b1, 8'h10};
        vecs[15] = '{1, 2, 1'b1, 8'h00};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", 32'(cs0), 32'h7F);
        chk("rst_wf", 32'(wf0), 32'h1);
        chk("rst_rf", 32'(rf0), 32'h1);
        chk("rst_a0", 32'(a00), 32'h1);
        chk("rst_data", 32'(dout0), 32'h0);
        chk("rst_oe", 32'(oe0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_idone", 32'(idone0), 32'h0);
        chk("rst_ack", 32'(ack0), 32'h0);
        chk("rst_err", 32'(err0), 32'h0);

        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_no_bus", 32'(cs0), 32'h7F);

        // Runtime request raised before init: must be held off.
        req = 1'b1; tgt = 3'd0; ra0 = 1'b0; rdata = 8'h20;
        tick();
        chk("req_held_off_busy", 32'(busy0), 32'h0);
        chk("req_held_off_cs", 32'(cs0), 32'h7F);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy0), 32'h1);
        chk("start_cs", 32'(cs0), 32'h7E);
        chk("start_a0", 32'(a00), 32'h0);
        chk("start_data", 32'(dout0), 32'h11);
        chk("start_oe", 32'(oe0), 32'h1);
        chk("start_wf", 32'(wf0), 32'h1);

        cycles = 0; acks = 0;
        while (busy0 && cycles < 400) begin
            start = (cycles == 50);
            tick();
            cycles++;
            if (ack0) acks++;
        end
        start = 1'b0;
        chk("init_cycles", 32'(cycles), 32'd175);
        chk("init_done", 32'(idone0), 32'h1);
        chk("no_ack_during_init", 32'(acks), 32'd0);
        chk("init_write_count", 32'(wq.size()), 32'd35);
        chk("wr1_pulses", 32'(pulses1), 32'd35);
        chk("wr1_wide", 32'(wide1), 32'd0);
        chk("wr1_init_done", 32'(idone1), 32'h1);

        for (int k = 0; k < 16; k++) begin
            idx = vecs[k].chip * 5 + vecs[k].step;
            ecs = 7'h7F;
            ecs[vecs[k].chip] = 1'b0;
            if (idx < wq.size()) begin
                chk($sformatf("vec%0d_cs", k), 32'(wq[idx].cs), 32'(ecs));
                chk($sformatf("vec%0d_a0", k), 32'(wq[idx].a0), 32'(vecs[k].a0));
                chk($sformatf("vec%0d_data", k), 32'(wq[idx].data), 32'(vecs[k].data));
            end else begin
                chk($sformatf("vec%0d_present", k), 32'(wq.size()), 32'(idx + 1));
            end
        end

        // Pending request now executes.
        tick();
        chk("rt_busy", 32'(busy0), 32'h1);
        chk("rt_cs", 32'(cs0), 32'h7E);
        chk("rt_a0", 32'(a00), 32'h0);
        chk("rt_data", 32'(dout0), 32'h20);
        c = 0;
        while (!ack0 && c < 20) begin
            tick();
            c++;
        end
        chk("rt_ack_latency", 32'(c), 32'd5);
        chk("rt_ack_busy", 32'(busy0), 32'h0);
        req = 1'b0;
        tick();
        chk("rt_ack_pulse", 32'(ack0), 32'h0);
        chk("rt_write_count", 32'(wq.size()), 32'd36);
        if (wq.size() == 36) chk("rt_write", 32'(wq[35]), 32'({7'h7E, 1'b0, 8'h20}));

        // Bad target: error pulse only.
        tgt = 3'd7; req = 1'b1;
        tick();
        chk("err_pulse", 32'(err0), 32'h1);
        chk("err_cs", 32'(cs0), 32'h7F);
        chk("err_busy", 32'(busy0), 32'h0);
        req = 1'b0; tgt = 3'd0;
        tick();
        chk("err_clear", 32'(err0), 32'h0);
        chk("err_no_write", 32'(wq.size()), 32'd36);

        // Reset during chip 2 strobe.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_idone_clr", 32'(idone0), 32'h0);
        c = 0;
        while (!(cs0 == 7'h7B && !wf0) && c < 300) begin
            tick();
            c++;
        end
        chk("chip2_strobe_found", 32'(c < 300), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs", 32'(cs0), 32'h7F);
        chk("arst_wf", 32'(wf0), 32'h1);
        chk("arst_a0", 32'(a00), 32'h1);
        chk("arst_data", 32'(dout0), 32'h0);
        chk("arst_oe", 32'(oe0), 32'h0);
        chk("arst_busy", 32'(busy0), 32'h0);
        chk("arst_idone", 32'(idone0), 32'h0);
        tick();
        rst_n = 1'b1;
        n = wq.size();
        repeat (5) tick();
        chk("post_rst_quiet_cs", 32'(cs0), 32'h7F);
        chk("post_rst_quiet_busy", 32'(busy0), 32'h0);
        chk("post_rst_no_write", 32'(wq.size()), 32'(n));

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("reinit_cs", 32'(cs0), 32'h7E);
        chk("reinit_a0", 32'(a00), 32'h0);
        chk("reinit_data", 32'(dout0), 32'h11);
        c = 0;
        while (busy0 && c < 400) begin
            tick();
            c++;
        end
        chk("reinit_cycles", 32'(c), 32'd175);
        chk("reinit_count", 32'(wq.size()), 32'(n + 35));
        if (wq.size() > n + 1) chk("reinit_icw2", 32'(wq[n+1].data), 32'h08);

        chk("protocol_violations", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
